// File: rtl/match_pkg.sv
// Shared state encoding, widths and per-state control decode for the match sequencer.
package match_pkg;

  localparam int unsigned TOTAL_W_DEF = 8;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned LIVES_W     = 3;
  // SERVE counter start: one decrementing tick plus the expiring tick = two tick pulses
  localparam int unsigned SERVE_TICKS = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_SERVE = 3'd2,
    ST_RALLY = 3'd3,
    ST_PAUSE = 3'd4,
    ST_MISS  = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  typedef struct packed {
    logic start;
    logic clear;
    logic stall;
    logic game_over;
  } ctl_t;

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_IDLE:  c.clear = 1'b1;
      ST_READY: c.clear = 1'b1;
      ST_SERVE: c.start = 1'b1;
      ST_RALLY: c = '0;
      ST_PAUSE: c.stall = 1'b1;
      ST_MISS:  c.stall = 1'b1;
      ST_OVER:  begin
        c.clear     = 1'b1;
        c.game_over = 1'b1;
      end
      default:  c.clear = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/match_sequencer_edge_rise.sv
// Registered rising-edge detector; the pulse appears one clk after the level rises.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_level;
      r_rise <= i_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/match_sequencer.sv
// Game-level sequencer driving the ball-motion block through serve/rally/miss/over.
// Optional HIGH_SCORE_EN adds a best_score register updated on entry to OVER.
module match_sequencer
  import match_pkg::*;
#(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned READY_TICKS = 24,
  parameter int unsigned MISS_TICKS  = 48,
  parameter int unsigned TOTAL_W     = TOTAL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               key_start,
  input  logic               key_pause,
  input  logic               ball_break,
  input  logic [3:0]         rally_score,
  output logic               start,
  output logic               clear,
  output logic               stall,
  output logic [LIVES_W-1:0] lives,
  output logic [TOTAL_W-1:0] total_score,
  output logic [2:0]         state_code,
  output logic               game_over
`ifdef HIGH_SCORE_EN
  ,
  output logic [TOTAL_W-1:0] best_score
`endif
);

  localparam logic [CNT_W-1:0]   READY_LD   = CNT_W'(READY_TICKS);
  localparam logic [CNT_W-1:0]   MISS_LD    = CNT_W'(MISS_TICKS);
  localparam logic [CNT_W-1:0]   SERVE_LD   = CNT_W'(SERVE_TICKS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  logic w_start_rise;
  logic w_pause_rise;
  logic w_break_rise;

  edge_rise u_start_edge (.clk(clk), .rst_n(rst_n), .i_level(key_start),  .o_rise(w_start_rise));
  edge_rise u_pause_edge (.clk(clk), .rst_n(rst_n), .i_level(key_pause),  .o_rise(w_pause_rise));
  edge_rise u_break_edge (.clk(clk), .rst_n(rst_n), .i_level(ball_break), .o_rise(w_break_rise));

  state_t             r_state;
  ctl_t               r_ctl;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_break_pend;
  logic [LIVES_W-1:0] r_lives;
  logic [TOTAL_W-1:0] r_total;

  logic [TOTAL_W:0]   w_sum;
  logic [TOTAL_W-1:0] w_total_sat;
  logic [LIVES_W-1:0] w_lives_dec;
  logic               w_expire;

  assign w_sum       = {1'b0, r_total} + {{(TOTAL_W-3){1'b0}}, rally_score};
  assign w_total_sat = w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
  assign w_lives_dec = (r_lives == '0) ? '0 : r_lives - 1'b1;
  assign w_expire    = tick && (r_cnt == '0);

  // Counter decrements by default; state-entry loads below override it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ctl        <= ctl_of(ST_IDLE);
      r_cnt        <= '0;
      r_break_pend <= 1'b0;
      r_lives      <= '0;
      r_total      <= '0;
    end else begin
      if (tick && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        ST_IDLE: if (w_start_rise) begin
          r_state      <= ST_READY;
          r_ctl        <= ctl_of(ST_READY);
          r_cnt        <= READY_LD;
          r_lives      <= LIVES_INIT;
          r_total      <= '0;
          r_break_pend <= 1'b0;
        end
        ST_READY: if (w_expire) begin
          r_state <= ST_SERVE;
          r_ctl   <= ctl_of(ST_SERVE);
          r_cnt   <= SERVE_LD;
        end
        ST_SERVE: if (w_expire) begin
          r_state <= ST_RALLY;
          r_ctl   <= ctl_of(ST_RALLY);
        end
        ST_RALLY: begin
          // A break latched during PAUSE is taken here, and break beats pause.
          if (w_break_rise || r_break_pend) begin
            r_state      <= ST_MISS;
            r_ctl        <= ctl_of(ST_MISS);
            r_cnt        <= MISS_LD;
            r_total      <= w_total_sat;
            r_lives      <= w_lives_dec;
            r_break_pend <= 1'b0;
          end else if (w_pause_rise) begin
            r_state <= ST_PAUSE;
            r_ctl   <= ctl_of(ST_PAUSE);
          end
        end
        ST_PAUSE: begin
          if (w_break_rise) r_break_pend <= 1'b1;
          if (w_pause_rise) begin
            r_state <= ST_RALLY;
            r_ctl   <= ctl_of(ST_RALLY);
          end
        end
        ST_MISS: if (w_expire) begin
          if (r_lives == '0) begin
            r_state <= ST_OVER;
            r_ctl   <= ctl_of(ST_OVER);
          end else begin
            r_state <= ST_READY;
            r_ctl   <= ctl_of(ST_READY);
            r_cnt   <= READY_LD;
          end
        end
        ST_OVER: if (w_start_rise) begin
          r_state <= ST_IDLE;
          r_ctl   <= ctl_of(ST_IDLE);
        end
        default: begin
          r_state <= ST_IDLE;
          r_ctl   <= ctl_of(ST_IDLE);
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [TOTAL_W-1:0] r_best;
  logic               w_enter_over;

  assign w_enter_over = (r_state == ST_MISS) && w_expire && (r_lives == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best <= '0;
    end else if (w_enter_over && (r_total > r_best)) begin
      r_best <= r_total;
    end
  end

  assign best_score = r_best;
`endif

  assign start       = r_ctl.start;
  assign clear       = r_ctl.clear;
  assign stall       = r_ctl.stall;
  assign game_over   = r_ctl.game_over;
  assign lives       = r_lives;
  assign total_score = r_total;
  assign state_code  = r_state;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer; covers best_score when HIGH_SCORE_EN is defined.
module tb_match_sequencer;

  localparam int unsigned TB_LIVES = 3;
  localparam int unsigned TB_READY = 24;
  localparam int unsigned TB_MISS  = 48;
  localparam int unsigned TB_TW    = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_SERVE = 3'd2;
  localparam logic [2:0] S_RALLY = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_MISS  = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             key_start = 1'b0;
  logic             key_pause = 1'b0;
  logic             ball_break = 1'b0;
  logic [3:0]       rally_score = 4'd0;
  logic             start;
  logic             clear;
  logic             stall;
  logic [2:0]       lives;
  logic [TB_TW-1:0] total_score;
  logic [2:0]       state_code;
  logic             game_over;
`ifdef HIGH_SCORE_EN
  logic [TB_TW-1:0] best_score;
`endif

  match_sequencer #(
    .LIVES(TB_LIVES),
    .READY_TICKS(TB_READY),
    .MISS_TICKS(TB_MISS),
    .TOTAL_W(TB_TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .key_start(key_start),
    .key_pause(key_pause),
    .ball_break(ball_break),
    .rally_score(rally_score),
    .start(start),
    .clear(clear),
    .stall(stall),
    .lives(lives),
    .total_score(total_score),
    .state_code(state_code),
    .game_over(game_over)
`ifdef HIGH_SCORE_EN
    , .best_score(best_score)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_ready = 0;
  int          n_serve = 0;
  int          n_miss = 0;
  logic        tick_en = 1'b0;
  int unsigned div = 0;
  logic [2:0]  st_prev = 3'd0;

  // Ticks are driven on negedge; each is attributed to the state it met at the posedge.
  always @(negedge clk) begin
    if (tick) begin
      case (st_prev)
        S_READY: n_ready++;
        S_SERVE: n_serve++;
        S_MISS:  n_miss++;
        default: ;
      endcase
    end
    st_prev = state_code;
    div++;
    tick = tick_en && ((div % 4) == 0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] code, input int budget);
    int k;
    k = 0;
    while ((state_code !== code) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, {29'd0, state_code}, {29'd0, code});
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    cycles(2);
    key_start = 1'b0;
    cycles(1);
  endtask

  task automatic pulse_pause();
    key_pause = 1'b1;
    cycles(2);
    key_pause = 1'b0;
    cycles(1);
  endtask

  task automatic raise_break();
    ball_break = 1'b1;
    cycles(2);
    ball_break = 1'b0;
  endtask

  task automatic play_miss(input logic [3:0] s, input int exp_total, input int exp_lives);
    wait_state("rally_before_miss", S_RALLY, 700);
    rally_score = s;
    raise_break();
    wait_state("miss_entry", S_MISS, 10);
    check_eq("miss_total", {27'd0, total_score}, exp_total);
    check_eq("miss_lives", {29'd0, lives}, exp_lives);
  endtask

  // From OVER: leave to IDLE, start a new game, lose all three balls.
  task automatic play_game(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                           input int t0, input int t1, input int t2);
    pulse_start();
    wait_state("over_to_idle", S_IDLE, 10);
    pulse_start();
    wait_state("idle_to_ready", S_READY, 10);
    check_eq("new_game_total", {27'd0, total_score}, 0);
    check_eq("new_game_lives", {29'd0, lives}, TB_LIVES);
    play_miss(s0, t0, 2);
    play_miss(s1, t1, 1);
    play_miss(s2, t2, 0);
    wait_state("game_over", S_OVER, 700);
    check_eq("game_over_flag", {31'd0, game_over}, 1);
  endtask

  initial begin
    int n_rc;
    int k;

    // Reset state
    cycles(3);
    check_eq("rst_state", {29'd0, state_code}, S_IDLE);
    check_eq("rst_clear", {31'd0, clear}, 1);
    check_eq("rst_start", {31'd0, start}, 0);
    check_eq("rst_stall", {31'd0, stall}, 0);
    check_eq("rst_over",  {31'd0, game_over}, 0);
    check_eq("rst_lives", {29'd0, lives}, 0);
    check_eq("rst_total", {27'd0, total_score}, 0);
    rst_n   = 1'b1;
    tick_en = 1'b1;
    cycles(5);
    check_eq("idle_holds", {29'd0, state_code}, S_IDLE);

    // Normal serve: READY sees READY_TICKS decrementing ticks plus the expiring one
    n_ready = 0;
    n_serve = 0;
    pulse_start();
    wait_state("enter_ready", S_READY, 10);
    check_eq("ready_lives", {29'd0, lives}, 3);
    check_eq("ready_clear", {31'd0, clear}, 1);
    wait_state("enter_serve", S_SERVE, 600);
    #1;
    check_eq("ready_ticks", n_ready, TB_READY + 1);
    check_eq("serve_start", {31'd0, start}, 1);
    check_eq("serve_clear", {31'd0, clear}, 0);
    wait_state("enter_rally", S_RALLY, 100);
    #1;
    check_eq("serve_ticks", n_serve, 2);
    check_eq("rally_start", {31'd0, start}, 0);
    check_eq("rally_lives", {29'd0, lives}, 3);

    // key_start ignored in RALLY
    pulse_start();
    cycles(2);
    check_eq("start_ignored", {29'd0, state_code}, S_RALLY);

    // Miss accounting
    rally_score = 4'd7;
    n_miss = 0;
    raise_break();
    wait_state("miss1", S_MISS, 10);
    check_eq("miss1_total", {27'd0, total_score}, 7);
    check_eq("miss1_lives", {29'd0, lives}, 2);
    check_eq("miss1_stall", {31'd0, stall}, 1);
    wait_state("miss1_to_ready", S_READY, 600);
    #1;
    check_eq("miss_ticks", n_miss, TB_MISS + 1);

    // Pause, break latched during PAUSE, resume
    wait_state("rally2", S_RALLY, 600);
    pulse_pause();
    wait_state("pause", S_PAUSE, 10);
    check_eq("pause_stall", {31'd0, stall}, 1);
    rally_score = 4'd3;
    raise_break();
    cycles(4);
    check_eq("pause_holds", {29'd0, state_code}, S_PAUSE);
    check_eq("pause_total", {27'd0, total_score}, 7);
    key_pause = 1'b1;
    n_rc = 0;
    k = 0;
    while ((state_code !== S_MISS) && (k < 20)) begin
      @(negedge clk);
      if (state_code === S_RALLY) n_rc++;
      k++;
    end
    key_pause = 1'b0;
    check_eq("pend_miss", {29'd0, state_code}, S_MISS);
    check_eq("pend_rally_cycles", n_rc, 1);
    check_eq("pend_lives", {29'd0, lives}, 1);
    check_eq("pend_total", {27'd0, total_score}, 10);

    // Break and pause edges together: break wins
    wait_state("rally3", S_RALLY, 700);
    rally_score = 4'd0;
    key_pause   = 1'b1;
    ball_break  = 1'b1;
    cycles(2);
    key_pause  = 1'b0;
    ball_break = 1'b0;
    check_eq("brk_beats_pause", {29'd0, state_code}, S_MISS);
    check_eq("brk_lives", {29'd0, lives}, 0);
    wait_state("over1", S_OVER, 700);
    check_eq("over1_flag",  {31'd0, game_over}, 1);
    check_eq("over1_clear", {31'd0, clear}, 1);
    check_eq("over1_total", {27'd0, total_score}, 10);
`ifdef HIGH_SCORE_EN
    check_eq("best_after_g1", {27'd0, best_score}, 10);
`endif

    // Game 2: saturation of a 5-bit total (15, 30, then 31)
    play_game(4'd15, 4'd15, 4'd15, 15, 30, 31);
    check_eq("g2_total_sat", {27'd0, total_score}, 31);
`ifdef HIGH_SCORE_EN
    check_eq("best_after_g2", {27'd0, best_score}, 31);
`endif

    // Game 3: lower total, best must hold
    play_game(4'd4, 4'd0, 4'd0, 4, 4, 4);
`ifdef HIGH_SCORE_EN
    check_eq("best_after_g3", {27'd0, best_score}, 31);
`endif

    // Reset mid-RALLY
    pulse_start();
    wait_state("g4_idle", S_IDLE, 10);
    pulse_start();
    wait_state("g4_rally", S_RALLY, 700);
    cycles(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_state", {29'd0, state_code}, S_IDLE);
    check_eq("mid_rst_clear", {31'd0, clear}, 1);
    check_eq("mid_rst_start", {31'd0, start}, 0);
    check_eq("mid_rst_lives", {29'd0, lives}, 0);
    check_eq("mid_rst_total", {27'd0, total_score}, 0);
`ifdef HIGH_SCORE_EN
    check_eq("mid_rst_best", {27'd0, best_score}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
